// File: rtl/sha1_pad.sv
// rtl/sha1_pad.sv - FIPS 180 message padder and 16-word block sequencer feeding the SHA-1 core
// Optional feature macro SHA1_PAD_EMPTY_EN: iBytes==0 on a last word means zero valid bytes.
module sha1_pad #(
  parameter int LENW     = 64,
  parameter int WORDNUM  = 16,
  parameter int WORDSIZE = 32
) (
  input  logic                iClk,
  input  logic                reset,
  input  logic [WORDSIZE-1:0] iDat,
  input  logic                iValid,
  input  logic                iLast,
  input  logic [2:0]          iBytes,
  output logic                oReady,
  output logic [WORDSIZE-1:0] oDat,
  output logic                oValid,
  output logic                oInitial,
  input  logic                iCoreReady
);

  typedef enum logic [2:0] {FILL, PAD, WAIT, SEND, PAD2} stateT;

  stateT               state, stateNext;
  logic [WORDSIZE-1:0] blockBuf [WORDNUM];
  logic [3:0]          widx, sidx;
  logic [LENW-1:0]     bitLen;
  logic                first, extra, markPend, lenFits, msgDone;
  logic [2:0]          nBytes;
  logic [31:0]         lastWord, padWord, wrData;
  logic                wrEn;
  logic [63:0]         lenField;

  assign lenField = 64'(bitLen);

  always_comb begin
    nBytes = 3'd4;
    if (iLast) begin
`ifdef SHA1_PAD_EMPTY_EN
      nBytes = (iBytes > 3'd4) ? 3'd4 : iBytes;
`else
      nBytes = (iBytes == 3'd0 || iBytes > 3'd4) ? 3'd4 : iBytes;
`endif
    end
  end

  // Unused tail bytes are zeroed and the marker lands in the first free byte.
  always_comb begin
    lastWord = iDat;
    case (nBytes)
      3'd0:    lastWord = 32'h8000_0000;
      3'd1:    lastWord = {iDat[31:24], 24'h80_0000};
      3'd2:    lastWord = {iDat[31:16], 16'h8000};
      3'd3:    lastWord = {iDat[31:8], 8'h80};
      default: lastWord = iDat;
    endcase
  end

  always_comb begin
    padWord = 32'h0;
    if (markPend)                      padWord = 32'h8000_0000;
    else if (lenFits && widx == 4'd14) padWord = lenField[63:32];
    else if (lenFits && widx == 4'd15) padWord = lenField[31:0];
  end

  always_comb begin
    stateNext = state;
    oReady    = 1'b0;
    wrEn      = 1'b0;
    wrData    = padWord;
    case (state)
      FILL: begin
        oReady = 1'b1;
        wrData = lastWord;
        if (iValid) begin
          wrEn = 1'b1;
          if (widx == 4'd15)  stateNext = WAIT;
          else if (iLast)     stateNext = PAD;
        end
      end
      PAD, PAD2: begin
        wrEn = 1'b1;
        if (widx == 4'd15) stateNext = WAIT;
      end
      WAIT:    if (iCoreReady) stateNext = SEND;
      SEND:    if (sidx == 4'd0) stateNext = extra ? PAD2 : FILL;
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge iClk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= stateNext;
  end

  always_ff @(posedge iClk) begin
    if (wrEn) blockBuf[widx] <= wrData;
  end

  always_ff @(posedge iClk or negedge reset) begin
    if (!reset) begin
      widx     <= 4'd0;
      sidx     <= 4'd0;
      bitLen   <= '0;
      first    <= 1'b1;
      extra    <= 1'b0;
      markPend <= 1'b0;
      lenFits  <= 1'b0;
      msgDone  <= 1'b0;
      oDat     <= '0;
      oValid   <= 1'b0;
      oInitial <= 1'b0;
    end else begin
      case (state)
        FILL: if (iValid) begin
          widx   <= widx + 4'd1;
          bitLen <= bitLen + LENW'({nBytes, 3'b000});
          if (iLast) begin
            msgDone  <= 1'b1;
            markPend <= (nBytes == 3'd4);
            lenFits  <= (nBytes != 3'd4) && (widx < 4'd14);
            if (widx == 4'd15) extra <= 1'b1;
          end
        end
        PAD, PAD2: begin
          widx <= widx + 4'd1;
          if (markPend) begin
            markPend <= 1'b0;
            lenFits  <= (widx < 4'd14);
          end
          if (state == PAD && widx == 4'd15) extra <= markPend | ~lenFits;
        end
        // Word 0 is launched here so oValid rises the cycle after iCoreReady is seen.
        WAIT: if (iCoreReady) begin
          oValid   <= 1'b1;
          oDat     <= blockBuf[0];
          oInitial <= first;
          first    <= 1'b0;
          sidx     <= 4'd1;
        end
        SEND: begin
          oInitial <= 1'b0;
          if (sidx != 4'd0) begin
            oDat <= blockBuf[sidx];
            sidx <= sidx + 4'd1;
          end else begin
            oValid <= 1'b0;
            widx   <= 4'd0;
            if (extra) begin
              extra   <= 1'b0;
              lenFits <= 1'b1;
            end else if (msgDone) begin
              msgDone <= 1'b0;
              bitLen  <= '0;
              first   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_pad.sv
// tb/tb_sha1_pad.sv - self-checking bench for sha1_pad using a byte-level padding model scoreboard
module tb_sha1_pad;

  logic        iClk = 1'b0;
  logic        reset;
  logic [31:0] iDat;
  logic        iValid, iLast, iBytes0;
  logic [2:0]  iBytes;
  logic        oReady, oValid, oInitial, iCoreReady;
  logic [31:0] oDat;

  sha1_pad dut (
    .iClk(iClk), .reset(reset), .iDat(iDat), .iValid(iValid), .iLast(iLast),
    .iBytes(iBytes), .oReady(oReady), .oDat(oDat), .oValid(oValid),
    .oInitial(oInitial), .iCoreReady(iCoreReady)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] dat;
    logic        ini;
  } expT;

  typedef struct {
    int          nWords;
    logic [31:0] w0;
    logic [2:0]  lastBytes;
    int          expBlocks;
    logic [31:0] expLenLo;
    logic        chkReady;
  } vecT;

  expT         expQ[$];
  expT         monE;
  vecT         vecs[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          runLen = 0;
  int          blocksSeen = 0;
  logic [31:0] lastSeen = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wordOf(input int i, input int n, input logic [31:0] w0);
    return (i == 0) ? w0 : {8'(i), 8'hC3, 8'(n), 8'h5A};
  endfunction

  // Reference: byte-serial FIPS 180 padding, then regrouped into big-endian words.
  task automatic pushModel(input int n, input logic [31:0] w0, input logic [2:0] lb);
    logic [7:0]  mb[$];
    logic [31:0] w;
    logic [63:0] bits;
    int          eff, nb;
    expT         e;
`ifdef SHA1_PAD_EMPTY_EN
    eff = int'(lb);
`else
    eff = (lb == 3'd0) ? 4 : int'(lb);
`endif
    for (int i = 0; i < n; i++) begin
      w  = wordOf(i, n, w0);
      nb = (i == n - 1) ? eff : 4;
      for (int b = 0; b < nb; b++) mb.push_back(w[31 - 8*b -: 8]);
    end
    bits = 64'(mb.size()) * 64'd8;
    mb.push_back(8'h80);
    while (mb.size() % 64 != 56) mb.push_back(8'h00);
    for (int b = 7; b >= 0; b--) mb.push_back(bits[8*b +: 8]);
    for (int k = 0; k < mb.size() / 4; k++) begin
      e.dat = {mb[4*k], mb[4*k+1], mb[4*k+2], mb[4*k+3]};
      e.ini = (k == 0);
      expQ.push_back(e);
    end
  endtask

  task automatic sendMsg(input int n, input logic [31:0] w0, input logic [2:0] lb);
    int guard;
    for (int i = 0; i < n; i++) begin
      iDat   = wordOf(i, n, w0);
      iValid = 1'b1;
      iLast  = (i == n - 1);
      iBytes = (i == n - 1) ? lb : 3'd0;
      guard  = 0;
      while (!oReady && guard < 1000) begin
        @(negedge iClk); #1;
        guard++;
      end
      if (guard >= 1000) check("oReady timeout", 32'(oReady), 32'd1);
      @(negedge iClk); #1;
    end
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 5000) begin
      @(negedge iClk); #1;
      guard++;
    end
    if (guard >= 5000) check("drain timeout", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge iClk);
    #1;
  endtask

  always @(negedge iClk) begin
    if (!reset) begin
      runLen = 0;
    end else if (oValid) begin
      if (expQ.size() == 0) begin
        check("unexpected oValid", 32'(oValid), 32'd0);
      end else begin
        monE = expQ.pop_front();
        check("oDat", oDat, monE.dat);
        check("oInitial", 32'(oInitial), 32'(monE.ini));
      end
      lastSeen = oDat;
      runLen++;
    end else if (runLen != 0) begin
      check("burst length", 32'(runLen), 32'd16);
      blocksSeen++;
      runLen = 0;
    end
  end

  initial begin
    int b0, hiCnt, guard;
    logic sawReady;

    iBytes0    = 1'b0;
    reset      = 1'b0;
    iDat       = 32'h0;
    iValid     = 1'b0;
    iLast      = 1'b0;
    iBytes     = 3'd0;
    iCoreReady = 1'b1;

    vecs.push_back('{1,  32'h6162_6300, 3'd3, 1, 32'h0000_0018, 1'b0});
    vecs.push_back('{14, 32'h0102_0304, 3'd4, 2, 32'h0000_01C0, 1'b0});
    vecs.push_back('{16, 32'h1111_2222, 3'd4, 2, 32'h0000_0200, 1'b1});
`ifdef SHA1_PAD_EMPTY_EN
    vecs.push_back('{1,  32'hDEAD_BEEF, 3'd0, 1, 32'h0000_0000, 1'b0});
`else
    vecs.push_back('{1,  32'hDEAD_BEEF, 3'd0, 1, 32'h0000_0020, 1'b0});
`endif
    vecs.push_back('{14, 32'hAAAA_5555, 3'd3, 1, 32'h0000_01B8, 1'b0});
    vecs.push_back('{15, 32'h0BAD_F00D, 3'd4, 2, 32'h0000_01E0, 1'b0});
    vecs.push_back('{16, 32'h1234_5678, 3'd1, 2, 32'h0000_01E8, 1'b0});
    vecs.push_back('{21, 32'hCAFE_BABE, 3'd2, 2, 32'h0000_0290, 1'b0});
    vecs.push_back('{2,  32'h6162_6364, 3'd4, 1, 32'h0000_0040, 1'b0});

    repeat (3) @(negedge iClk);
    #1;
    check("reset oReady", 32'(oReady), 32'd1);
    check("reset oValid", 32'(oValid), 32'd0);
    check("reset oInitial", 32'(oInitial), 32'd0);
    check("reset oDat", oDat, 32'h0);
    reset = 1'b1;
    @(negedge iClk); #1;

    foreach (vecs[v]) begin
      b0 = blocksSeen;
      pushModel(vecs[v].nWords, vecs[v].w0, vecs[v].lastBytes);
      sendMsg(vecs[v].nWords, vecs[v].w0, vecs[v].lastBytes);
      if (vecs[v].chkReady) begin
        sawReady = 1'b0;
        guard    = 0;
        while (expQ.size() != 0 && guard < 2000) begin
          if (oReady) sawReady = 1'b1;
          @(negedge iClk); #1;
          guard++;
        end
        check("oReady low until block2 done", 32'(sawReady), 32'd0);
      end
      waitDrain();
      if (vecs[v].chkReady) check("oReady after block2", 32'(oReady), 32'd1);
      check("block count", 32'(blocksSeen - b0), 32'(vecs[v].expBlocks));
      check("length word", lastSeen, vecs[v].expLenLo);
    end

    // Core stalled in WAIT: nothing may leave until iCoreReady rises.
    iCoreReady = 1'b0;
    b0 = blocksSeen;
    pushModel(1, 32'h6162_6300, 3'd3);
    sendMsg(1, 32'h6162_6300, 3'd3);
    hiCnt = 0;
    repeat (50) begin
      @(negedge iClk); #1;
      if (oValid) hiCnt++;
    end
    check("oValid while stalled", 32'(hiCnt), 32'd0);
    iCoreReady = 1'b1;
    @(negedge iClk); #1;
    check("oValid 1 cycle after ready", 32'(oValid), 32'd1);
    waitDrain();
    check("stall block count", 32'(blocksSeen - b0), 32'd1);

    // Reset in the middle of a burst.
    pushModel(10, 32'h7777_0000, 3'd4);
    sendMsg(10, 32'h7777_0000, 3'd4);
    guard = 0;
    while (runLen != 8 && guard < 500) begin
      @(negedge iClk); #2;
      guard++;
    end
    check("reached word 7", 32'(runLen), 32'd8);
    reset = 1'b0;
    #1;
    check("mid-burst reset oValid", 32'(oValid), 32'd0);
    check("mid-burst reset oReady", 32'(oReady), 32'd1);
    expQ.delete();
    runLen = 0;
    @(negedge iClk); #1;
    reset = 1'b1;
    @(negedge iClk); #1;
    b0 = blocksSeen;
    pushModel(1, 32'h6162_6300, 3'd3);
    sendMsg(1, 32'h6162_6300, 3'd3);
    waitDrain();
    check("post-reset block count", 32'(blocksSeen - b0), 32'd1);
    check("post-reset length word", lastSeen, 32'h0000_0018);
    check("scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha1_pad.md
# sha1_pad

Message padder and block sequencer that sits directly upstream of the SHA-1 core. It accepts a big-endian 32-bit word stream per message, applies FIPS 180 padding (0x80 marker, zero fill, 64-bit bit length), and bursts each 512-bit block into the core as 16 consecutive words once the core reports ready. `oInitial` is raised only on the first block of each message, so the core reloads its initial hash values there.

## Interface
- `LENW`, 64: width of the message bit-length counter (≤64); zero-extended into the 64-bit length field.
- `WORDNUM`, 16: words per block; fixed.
- `WORDSIZE`, 32: word width; fixed.

Ports:
- `iClk` in 1: the only clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `iDat` in 32: message word; first byte is in [31:24].
- `iValid` in 1: upstream word valid.
- `iLast` in 1: qualifies the final word of the message.
- `iBytes` in 3: valid bytes in the last word, left-justified; 1–4. Value 0 is defined under Configuration.
- `oReady` out 1: padder accepts a word; a transfer occurs when `iValid & oReady`.
- `oDat` out 32: word to the core `iDat`; registered.
- `oValid` out 1: to core `iValid`; high for exactly 16 consecutive cycles per block.
- `oInitial` out 1: to core `iInitial`; high only with word 0 of a message's first block.
- `iCoreReady` in 1: the core's `oReady`.

## Operation
- Holds a 16×32 block buffer, a write index `widx` (0–15), a send index `sidx`, a byte counter, and a first-block flag.
- **FILL**
  - `oReady=1`. Each transfer writes `buf[widx]`, increments `widx`, and adds 4 bytes (or `iBytes` on the last word) to the count.
  - Non-last word with `widx==15`: go to WAIT.
  - Last word: unused bytes are forced to 0. If fewer than 4 bytes are valid, 0x80 is placed in the first unused byte. Then go to PAD.
- **PAD**, one word per cycle, `oReady=0`:
  - If the marker is still pending, the next word is 0x80000000.
  - Then zero words.
  - Words 14/15 take length[63:32]/length[31:0] only if the marker landed in words 0–13.
  - Otherwise the block is zero-filled to word 15 and an extra-block flag is set. Then go to WAIT.
- **WAIT**: when `iCoreReady==1`, go to SEND.
- **SEND**
  - For 16 cycles, drive `oDat=buf[sidx]` with `oValid=1`, `sidx` 0→15. `oInitial=1` on `sidx==0` if the first-block flag is set; the flag is then cleared.
  - After word 15: if the extra-block flag is set, go to PAD2; if the message is finished, clear state (count=0, first=1) and go to FILL; otherwise go to FILL with `widx=0`.
- **PAD2**: words 0–13 are zero, or word 0 is 0x80000000 if the marker is still pending. Words 14/15 take the length. Then go to WAIT.
- Length = byte count × 8, modulo 2^LENW; wrap-around is silent.
- Transfers with `oReady=0` are ignored; upstream must hold the word.

## Timing
- Reset values: `oReady=1`, `oValid=0`, `oInitial=0`, `oDat=0`, state FILL, `widx=0`, count 0, first-block flag 1.
- Reset asserted mid-burst drops `oValid` immediately and discards the message. The core must be reset alongside.
- WAIT→SEND: the first `oValid` cycle is the cycle after `iCoreReady` is sampled high. The core is then at its idle loop, and `iCoreReady` cannot fall during SEND.
- PAD lasts 16−`widx` cycles; PAD2 lasts 16 cycles.
- A full message block reaches the core no earlier than 2 cycles after the last word is accepted.
- `oValid` never gaps within a block; the core samples words 0–15 on consecutive edges.

## Configuration
- `SHA1_PAD_EMPTY_EN` defined: `iBytes==0` with `iLast` is a zero-byte final word. Its bytes are discarded and it is not counted, which allows an empty message (a single word with `iLast`, `iBytes=0`).
- Not defined: `iBytes==0` is treated as 4.

## Test plan
- "abc": one word 0x61626300, `iLast`, `iBytes=3` → one block: word0 0x61626380, words1–14 0, word15 0x00000018; `oInitial` high on word0 only.
- 56-byte message (14 full words, last `iBytes=4`) → block1: data, word14 0x80000000, word15 0; block2: words0–14 0, word15 0x000001C0; `oInitial` high only on block1.
- 64-byte message → block1: 16 data words; block2: word0 0x80000000, word15 0x00000200. `oReady` is low from acceptance of word15 until block2 completes.
- With `SHA1_PAD_EMPTY_EN`, empty message → one block: word0 0x80000000, all other words 0. Without the macro, the same stimulus → word0 = data, word1 0x80000000, word15 0x00000020.
- Hold `iCoreReady=0` for 50 cycles in WAIT → `oValid` stays 0; SEND starts 1 cycle after `iCoreReady` rises, with 16 contiguous valid cycles.
- Assert `reset` low at `sidx=7` → `oValid=0` and `oReady=1` asynchronously; the next message's first block carries `oInitial`.
